// File: rtl/hawk_axi_rd_mstr.sv
// HAWK AXI4 read master: single-request INCR bursts on AR/R with a response FIFO.
// Define HAWK_RD_ERRCNT_EN to build the saturating non-OKAY beat counter.
package hacd_pkg;
   localparam int HACD_AXI4_ADDR_WIDTH = 64;
   localparam int HACD_AXI4_DATA_WIDTH = 512;
   localparam int HACD_AXI4_ID_WIDTH   = 4;
   localparam int HACD_AXI4_RESP_WIDTH = 2;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [7:0]                      arlen;
      logic                            arvalid;
      logic                            rready;
   } axi_rd_reqpkt_t;

   typedef struct packed {
      logic arready;
   } axi_rd_rdypkt_t;

   typedef struct packed {
      logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
      logic [HACD_AXI4_RESP_WIDTH-1:0] rresp;
      logic                            rlast;
      logic                            rvalid;
   } axi_rd_resppkt_t;
endpackage

module hawk_axi_rd_mstr
   import hacd_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int AXI_ID     = 0
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  axi_rd_reqpkt_t                   rd_reqpkt,
   output axi_rd_rdypkt_t                   rd_rdypkt,
   output axi_rd_resppkt_t                  rd_resppkt,
   input  logic                             rdm_reset,
   output logic                             rdfifo_full,
   output logic                             rdfifo_empty,
   output logic [HACD_AXI4_ADDR_WIDTH-1:0]  m_axi_araddr,
   output logic [7:0]                       m_axi_arlen,
   output logic [2:0]                       m_axi_arsize,
   output logic [1:0]                       m_axi_arburst,
   output logic [HACD_AXI4_ID_WIDTH-1:0]    m_axi_arid,
   output logic                             m_axi_arvalid,
   input  logic                             m_axi_arready,
   input  logic [HACD_AXI4_DATA_WIDTH-1:0]  m_axi_rdata,
   input  logic [HACD_AXI4_RESP_WIDTH-1:0]  m_axi_rresp,
   input  logic                             m_axi_rlast,
   input  logic                             m_axi_rvalid,
   output logic                             m_axi_rready,
   output logic [15:0]                      rd_err_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = HACD_AXI4_DATA_WIDTH + HACD_AXI4_RESP_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, AR_SEND, R_WAIT, DRAIN} state_e;

   state_e                          state_q, state_d;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]                      arlen_q, arlen_d;
   logic                            abort_q, abort_d;
   logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]                cnt_q;
   logic [ENT_W-1:0]                mem_q [FIFO_DEPTH];
   logic                            fifo_full, fifo_empty, r_hs, push, pop;

   assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign r_hs       = m_axi_rvalid && m_axi_rready;
   // A flush wins over any same-cycle push or pop.
   assign push       = r_hs && (state_q == R_WAIT) && !rdm_reset;
   assign pop        = !fifo_empty && rd_reqpkt.rready && !rdm_reset;

   always_comb begin
      state_d           = state_q;
      araddr_d          = araddr_q;
      arlen_d           = arlen_q;
      abort_d           = abort_q;
      rd_rdypkt         = '0;
      m_axi_arvalid     = 1'b0;
      m_axi_rready      = 1'b0;
      case (state_q)
         IDLE: begin
            rd_rdypkt.arready = !rdm_reset;
            if (rd_reqpkt.arvalid && !rdm_reset) begin
               araddr_d = rd_reqpkt.addr;
               arlen_d  = rd_reqpkt.arlen;
               abort_d  = 1'b0;
               state_d  = AR_SEND;
            end
         end
         AR_SEND: begin
            // The address phase cannot be withdrawn; a flush here only redirects the data.
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               state_d = (abort_q || rdm_reset) ? DRAIN : R_WAIT;
               abort_d = 1'b0;
            end else if (rdm_reset) begin
               abort_d = 1'b1;
            end
         end
         R_WAIT: begin
            m_axi_rready = !fifo_full;
            if (m_axi_rvalid && !fifo_full && m_axi_rlast) state_d = IDLE;
            else if (rdm_reset)                             state_d = DRAIN;
         end
         DRAIN: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid && m_axi_rlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         araddr_q <= '0;
         arlen_q  <= '0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
         abort_q  <= abort_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (rdm_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {m_axi_rdata, m_axi_rresp, m_axi_rlast};
   end

   always_comb begin
      {rd_resppkt.rdata, rd_resppkt.rresp, rd_resppkt.rlast} = mem_q[rd_ptr_q];
      rd_resppkt.rvalid = !fifo_empty;
   end

   assign rdfifo_full   = fifo_full;
   assign rdfifo_empty  = fifo_empty;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = 3'($clog2(HACD_AXI4_DATA_WIDTH / 8));
   assign m_axi_arburst = 2'b01;
   assign m_axi_arid    = HACD_AXI4_ID_WIDTH'(AXI_ID);

`ifdef HAWK_RD_ERRCNT_EN
   logic [15:0] err_cnt_q;

   // Counts every accepted non-OKAY beat, discarded ones included; cleared only by rst_ni.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                                  err_cnt_q <= '0;
      else if (r_hs && (m_axi_rresp != '0) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign rd_err_cnt = err_cnt_q;
`else
   assign rd_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hawk_axi_rd_mstr.sv
// Directed bench for hawk_axi_rd_mstr: AXI slave stub, transaction-level model and per-cycle compare.
module tb_hawk_axi_rd_mstr;
   import hacd_pkg::*;

   typedef logic [575:0] cv_t;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   axi_rd_reqpkt_t  rd_reqpkt;
   axi_rd_rdypkt_t  rd_rdypkt;
   axi_rd_resppkt_t rd_resppkt;
   logic            rdm_reset;
   logic            rdfifo_full, rdfifo_empty;
   logic [63:0]     m_axi_araddr;
   logic [7:0]      m_axi_arlen;
   logic [2:0]      m_axi_arsize;
   logic [1:0]      m_axi_arburst;
   logic [3:0]      m_axi_arid;
   logic            m_axi_arvalid, m_axi_arready;
   logic [511:0]    m_axi_rdata;
   logic [1:0]      m_axi_rresp;
   logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic [15:0]     rd_err_cnt;

   hawk_axi_rd_mstr #(.FIFO_DEPTH(DEPTH), .AXI_ID(0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rd_reqpkt(rd_reqpkt), .rd_rdypkt(rd_rdypkt),
      .rd_resppkt(rd_resppkt), .rdm_reset(rdm_reset), .rdfifo_full(rdfifo_full),
      .rdfifo_empty(rdfifo_empty), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .rd_err_cnt(rd_err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   // Transaction-level view: an open burst, whether its AR has gone, whether its data is being thrown away.
   logic [514:0] mq [$];
   logic         burst_open, ar_done, discarding, abort_pend;
   logic [63:0]  exp_addr;
   logic [7:0]   exp_len;
   int           err_model;

   // Slave stub state.
   logic [511:0] sq_d [$];
   logic [1:0]   sq_r [$];
   logic         sq_l [$];
   logic [31:0]  pat, errmask;

   // Observation counters.
   int           cyc = 0, pop_cnt, rlast_cnt, rlast_at, err_seen, beats_acc, ar_rise, rlast_edge;
   logic         arv_prev = 1'b0, req_done;
   logic [511:0] last_pop_data;

   task automatic check(input string nm, input cv_t act, input cv_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL timeout %s: got expired wait, want event within budget", nm);
   endtask

   task automatic model_reset();
      mq.delete();
      burst_open = 0; ar_done = 0; discarding = 0; abort_pend = 0;
      exp_addr = '0; exp_len = '0; err_model = 0;
   endtask

   task automatic slave_clear();
      sq_d.delete(); sq_r.delete(); sq_l.delete();
      m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0; m_axi_rresp = '0;
   endtask

   task automatic compare();
      logic [514:0] h;
      check("arready", cv_t'(rd_rdypkt.arready), cv_t'(!burst_open && !rdm_reset));
      check("arvalid", cv_t'(m_axi_arvalid), cv_t'(burst_open && !ar_done));
      check("araddr", cv_t'(m_axi_araddr), cv_t'(exp_addr));
      check("arlen", cv_t'(m_axi_arlen), cv_t'(exp_len));
      check("arsize", cv_t'(m_axi_arsize), cv_t'(3'd6));
      check("arburst", cv_t'(m_axi_arburst), cv_t'(2'd1));
      check("arid", cv_t'(m_axi_arid), cv_t'(4'd0));
      check("rready", cv_t'(m_axi_rready), cv_t'(burst_open && ar_done && (discarding || mq.size() < DEPTH)));
      check("rvalid", cv_t'(rd_resppkt.rvalid), cv_t'(mq.size() != 0));
      check("full", cv_t'(rdfifo_full), cv_t'(mq.size() == DEPTH));
      check("empty", cv_t'(rdfifo_empty), cv_t'(mq.size() == 0));
`ifdef HAWK_RD_ERRCNT_EN
      check("err_cnt", cv_t'(rd_err_cnt), cv_t'(err_model));
`else
      check("err_cnt", cv_t'(rd_err_cnt), cv_t'(16'd0));
`endif
      if (mq.size() != 0) begin
         h = mq[0];
         check("rdata", cv_t'(rd_resppkt.rdata), cv_t'(h[514:3]));
         check("rresp", cv_t'(rd_resppkt.rresp), cv_t'(h[2:1]));
         check("rlast", cv_t'(rd_resppkt.rlast), cv_t'(h[0]));
      end
   endtask

   // One clock: observe at the falling edge, then update model and slave just after the rising edge.
   task automatic step();
      logic ar_hs, r_hs, req_hs, pop_hs, rst_s;
      logic [514:0] beat;
      logic [7:0] len;
      @(negedge clk);
      if (rst_n) compare();
      ar_hs  = m_axi_arvalid && m_axi_arready;
      r_hs   = m_axi_rvalid && m_axi_rready;
      req_hs = rd_reqpkt.arvalid && rd_rdypkt.arready;
      pop_hs = rd_resppkt.rvalid && rd_reqpkt.rready;
      rst_s  = rdm_reset;
      beat   = {m_axi_rdata, m_axi_rresp, m_axi_rlast};
      len    = m_axi_arlen;
      if (pop_hs && !rst_s) begin
         pop_cnt++;
         last_pop_data = rd_resppkt.rdata;
         if (rd_resppkt.rresp == 2'd2) err_seen++;
         if (rd_resppkt.rlast) begin rlast_cnt++; rlast_at = pop_cnt - 1; end
      end
      if (m_axi_arvalid && !arv_prev) ar_rise = cyc;
      arv_prev = m_axi_arvalid;
      if (r_hs && m_axi_rlast) rlast_edge = cyc;
      if (req_hs) req_done = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         model_reset();
         slave_clear();
      end else begin
         if (pop_hs && !rst_s) void'(mq.pop_front());
         if (r_hs) begin
            beats_acc++;
            if (beat[2:1] != 2'd0 && err_model < 65535) err_model++;
            if (!rst_s && !discarding) mq.push_back(beat);
            if (beat[0]) begin burst_open = 0; discarding = 0; abort_pend = 0; end
         end
         if (rst_s) begin
            mq.delete();
            if (burst_open && !(r_hs && beat[0])) begin
               if (ar_done) discarding = 1;
               else         abort_pend = 1;
            end
         end
         if (ar_hs) begin
            ar_done = 1;
            if (abort_pend || rst_s) discarding = 1;
            abort_pend = 0;
         end
         if (req_hs) begin
            burst_open = 1; ar_done = 0; discarding = 0; abort_pend = 0;
            exp_addr = rd_reqpkt.addr; exp_len = rd_reqpkt.arlen;
         end
         if (r_hs) begin
            void'(sq_d.pop_front()); void'(sq_r.pop_front()); void'(sq_l.pop_front());
         end
         if (ar_hs) begin
            for (int i = 0; i <= int'(len); i++) begin
               sq_d.push_back({16{pat + 32'(i)}});
               sq_r.push_back((i < 32 && errmask[i]) ? 2'd2 : 2'd0);
               sq_l.push_back(i == int'(len));
            end
         end
         if (sq_d.size() != 0) begin
            m_axi_rvalid = 1; m_axi_rdata = sq_d[0]; m_axi_rresp = sq_r[0]; m_axi_rlast = sq_l[0];
         end else begin
            m_axi_rvalid = 0; m_axi_rlast = 0;
         end
      end
   endtask

   task automatic issue(input logic [63:0] a, input logic [7:0] l);
      int n = 0;
      rd_reqpkt.addr = a; rd_reqpkt.arlen = l; rd_reqpkt.arvalid = 1;
      req_done = 0;
      while (!req_done && n < 200) begin step(); n++; end
      rd_reqpkt.arvalid = 0;
      if (!req_done) tmo("issue");
   endtask

   task automatic wait_done(input string nm, input int budget, input bit need_empty);
      int n = 0;
      while ((burst_open || (need_empty && mq.size() != 0)) && n < budget) begin step(); n++; end
      if (burst_open || (need_empty && mq.size() != 0)) tmo(nm);
   endtask

   task automatic clr_counts();
      pop_cnt = 0; rlast_cnt = 0; rlast_at = -1; err_seen = 0; beats_acc = 0;
   endtask

   initial begin
      int n;
      rst_n = 0; rdm_reset = 0; rd_reqpkt = '0; m_axi_arready = 1;
      pat = '0; errmask = '0;
      model_reset(); slave_clear(); clr_counts();
      repeat (3) step();
      check("rst arvalid", cv_t'(m_axi_arvalid), cv_t'(1'b0));
      check("rst rready", cv_t'(m_axi_rready), cv_t'(1'b0));
      check("rst araddr", cv_t'(m_axi_araddr), cv_t'(64'd0));
      check("rst arlen", cv_t'(m_axi_arlen), cv_t'(8'd0));
      check("rst empty", cv_t'(rdfifo_empty), cv_t'(1'b1));
      check("rst full", cv_t'(rdfifo_full), cv_t'(1'b0));
      check("rst rvalid", cv_t'(rd_resppkt.rvalid), cv_t'(1'b0));
      check("rst errcnt", cv_t'(rd_err_cnt), cv_t'(16'd0));
      rst_n = 1;
      step();
      check("arready after rst", cv_t'(rd_rdypkt.arready), cv_t'(1'b1));

      // Single-beat read.
      pat = 32'hA5A5_A5A5; rd_reqpkt.rready = 1;
      issue(64'h8000_1000, 8'd0);
      check("t1 arvalid", cv_t'(m_axi_arvalid), cv_t'(1'b1));
      check("t1 araddr", cv_t'(m_axi_araddr), cv_t'(64'h8000_1000));
      check("t1 arlen", cv_t'(m_axi_arlen), cv_t'(8'd0));
      check("t1 arsize", cv_t'(m_axi_arsize), cv_t'(3'd6));
      check("t1 arburst", cv_t'(m_axi_arburst), cv_t'(2'd1));
      step();
      step();
      check("t1 rvalid", cv_t'(rd_resppkt.rvalid), cv_t'(1'b1));
      check("t1 rdata", cv_t'(rd_resppkt.rdata), cv_t'({16{32'hA5A5_A5A5}}));
      check("t1 rlast", cv_t'(rd_resppkt.rlast), cv_t'(1'b1));
      check("t1 arready", cv_t'(rd_rdypkt.arready), cv_t'(1'b1));
      wait_done("t1 drain", 20, 1);

      // 64-beat burst against a stalled consumer.
      clr_counts(); pat = 32'h0000_1000; rd_reqpkt.rready = 0;
      issue(64'h1000_0000, 8'd63);
      n = 0;
      while (mq.size() < DEPTH && n < 100) begin step(); n++; end
      if (mq.size() < DEPTH) tmo("t2 fill");
      check("t2 full", cv_t'(rdfifo_full), cv_t'(1'b1));
      check("t2 rready", cv_t'(m_axi_rready), cv_t'(1'b0));
      repeat (5) step();
      rd_reqpkt.rready = 1;
      wait_done("t2 deliver", 400, 1);
      check("t2 pops", cv_t'(pop_cnt), cv_t'(64));
      check("t2 rlast count", cv_t'(rlast_cnt), cv_t'(1));
      check("t2 rlast index", cv_t'(rlast_at), cv_t'(63));
      check("t2 last data", cv_t'(last_pop_data), cv_t'({16{32'h0000_103F}}));

      // Flush after beat 10 of a 64-beat burst.
      clr_counts(); pat = 32'h0000_2000; rd_reqpkt.rready = 0;
      issue(64'h2000_0000, 8'd63);
      n = 0;
      while (beats_acc < 11 && n < 100) begin step(); n++; end
      if (beats_acc < 11) tmo("t3 beats");
      rdm_reset = 1;
      step();
      rdm_reset = 0;
      check("t3 empty", cv_t'(rdfifo_empty), cv_t'(1'b1));
      check("t3 rvalid", cv_t'(rd_resppkt.rvalid), cv_t'(1'b0));
      check("t3 drain rready", cv_t'(m_axi_rready), cv_t'(1'b1));
      wait_done("t3 drain", 200, 0);
      check("t3 beats", cv_t'(beats_acc), cv_t'(64));
      check("t3 arready", cv_t'(rd_rdypkt.arready), cv_t'(1'b1));
      check("t3 pops", cv_t'(pop_cnt), cv_t'(0));

      // Flush while the address is still waiting for the interconnect.
      clr_counts(); m_axi_arready = 0;
      issue(64'h3000_0000, 8'd3);
      rdm_reset = 1;
      step();
      rdm_reset = 0;
      repeat (2) step();
      m_axi_arready = 1;
      wait_done("t3b drain", 50, 0);
      check("t3b beats", cv_t'(beats_acc), cv_t'(4));
      check("t3b pops", cv_t'(pop_cnt), cv_t'(0));
      check("t3b empty", cv_t'(rdfifo_empty), cv_t'(1'b1));

      // Error responses on beats 1 and 3.
      clr_counts(); pat = 32'h0000_4000; errmask = 32'b1010; rd_reqpkt.rready = 1;
      issue(64'h4000_0000, 8'd3);
      wait_done("t4", 50, 1);
      check("t4 rresp seen", cv_t'(err_seen), cv_t'(2));
`ifdef HAWK_RD_ERRCNT_EN
      check("t4 err_cnt", cv_t'(rd_err_cnt), cv_t'(16'd2));
`else
      check("t4 err_cnt", cv_t'(rd_err_cnt), cv_t'(16'd0));
`endif
      errmask = '0;

      // Back-to-back requests.
      clr_counts(); pat = 32'h0000_5000;
      issue(64'h5000_0000, 8'd7);
      step();
      issue(64'h5000_1000, 8'd1);
      step();
      check("t5 ar gap", cv_t'(ar_rise - rlast_edge), cv_t'(2));
      check("t5 araddr", cv_t'(m_axi_araddr), cv_t'(64'h5000_1000));
      wait_done("t5", 60, 1);
      check("t5 pops", cv_t'(pop_cnt), cv_t'(10));

      // Asynchronous reset mid-burst, then a clean single-beat read.
      clr_counts(); pat = 32'h0000_6000; rd_reqpkt.rready = 0;
      issue(64'h6000_0000, 8'd15);
      n = 0;
      while (beats_acc < 5 && n < 50) begin step(); n++; end
      if (beats_acc < 5) tmo("t6 beats");
      #2 rst_n = 0;
      #1;
      check("t6 arvalid", cv_t'(m_axi_arvalid), cv_t'(1'b0));
      check("t6 rready", cv_t'(m_axi_rready), cv_t'(1'b0));
      check("t6 araddr", cv_t'(m_axi_araddr), cv_t'(64'd0));
      check("t6 arlen", cv_t'(m_axi_arlen), cv_t'(8'd0));
      check("t6 empty", cv_t'(rdfifo_empty), cv_t'(1'b1));
      check("t6 full", cv_t'(rdfifo_full), cv_t'(1'b0));
      check("t6 rvalid", cv_t'(rd_resppkt.rvalid), cv_t'(1'b0));
      check("t6 errcnt", cv_t'(rd_err_cnt), cv_t'(16'd0));
      model_reset(); slave_clear();
      repeat (2) step();
      rst_n = 1;
      clr_counts(); pat = 32'hC0DE_0000; rd_reqpkt.rready = 1;
      issue(64'h7000_0040, 8'd0);
      wait_done("t6 read", 20, 1);
      check("t6 pops", cv_t'(pop_cnt), cv_t'(1));
      check("t6 data", cv_t'(last_pop_data), cv_t'({16{32'hC0DE_0000}}));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
